mem_port_arbiter: RTL
=====================

Name: mem_port_arbiter

Overview:
- Shares the single external memory port between the instruction cache and the data cache miss/write-back engines.
- Arbitrates round-robin and latches the granted request.
- Runs the memory read/write handshake and returns a one-cycle ready pulse with line data to the winner.
- The losing cache sees its ready held low; the pipeline stalls through the caches' existing stall outputs (the memory_stall seen by the execution stage).

Parameters:
- ADDR_W, 28, line address width (word address of a cache line).
- DATA_W, 128, line data width.
- CNT_W, 32, width of the contention performance counter.

Ports:
- clk  input  1  clock; all state on rising edge.
- rst  input  1  asynchronous, active-high reset.
- ic_read  input  1  I-cache line read request; held until ic_ready.
- ic_addr  input  ADDR_W  I-cache line address.
- ic_ready  output  1  one-cycle pulse: I-cache request complete.
- ic_rdata  output  DATA_W  line data; valid while ic_ready=1.
- dc_read  input  1  D-cache line read request; held until dc_ready.
- dc_write  input  1  D-cache line write-back request; held until dc_ready.
- dc_addr  input  ADDR_W  D-cache line address.
- dc_wdata  input  DATA_W  D-cache write-back data.
- dc_ready  output  1  one-cycle pulse: D-cache request complete.
- dc_rdata  output  DATA_W  line data; valid while dc_ready=1.
- mem_read  output  1  memory read strobe; registered.
- mem_write  output  1  memory write strobe; registered.
- mem_addr  output  ADDR_W  latched address of the granted request.
- mem_wdata  output  DATA_W  latched write data.
- mem_ready  input  1  memory completion; single-cycle pulse.
- mem_rdata  input  DATA_W  valid when mem_ready=1.
- contention_cnt  output  CNT_W  saturating count of cycles one cache waited while the other owned the port.

Behaviour:
- Reset (async, rst=1): state=IDLE, last_grant=IC. All outputs 0, including strobes, ready, rdata, addr, wdata and the counter.
- FSM states: IDLE, BUSY, RESP.
- IDLE, no request: stay in IDLE.
- IDLE, request present: grant and latch {owner, op, addr, wdata}, go to BUSY. mem_read/mem_write asserts in the next cycle.
- Simultaneous requests: grant the cache that was not last_grant. After reset, D first.
- dc_read and dc_write both high is illegal; dc_write wins.
- BUSY: strobe held high and mem_addr/mem_wdata held stable until the cycle mem_ready=1.
- On mem_ready: capture mem_rdata, clear the strobe at the next edge, go to RESP.
- RESP (one cycle): owner's ready=1 and owner's rdata=captured data. For writes, rdata=0. Update last_grant, then go to IDLE.
- Latency: request seen in IDLE at cycle 0 → strobe from cycle 1 → mem_ready at cycle k → ready at cycle k+1.
- Back-to-back turnaround: the next grant is made at cycle k+2 and its strobe appears at k+3.
- Requester contract: deassert the request, or present a new one, in the cycle after its ready pulse. Address and data changes while not granted are ignored until grant.
- mem_ready outside BUSY is ignored.
- ic_ready and dc_ready are never high together. Each pulses exactly once per granted transaction.
- contention_cnt increments in any cycle where state≠IDLE and the non-owner's request is high. It saturates at all-ones.
- Reset mid-transaction: immediate return to IDLE with strobes low. The memory transaction is abandoned, and a late mem_ready is ignored.

Test Plan:
- ic_read only, addr=0x0000040, mem_ready 4 cycles after mem_read rises, rdata=0x1111…1111 → mem_read high 4 cycles; ic_ready pulses 1 cycle with ic_rdata=0x1111…1111; dc_ready stays 0.
- dc_write addr=0x0000080, wdata=0xDEAD…BEEF → mem_write=1 with those values until mem_ready; dc_ready pulses, dc_rdata=0, mem_read never asserts.
- ic_read and dc_read asserted together after reset → D served first, then I. contention_cnt equals the D busy cycles, i.e. 3 for a 2-cycle memory latency plus RESP.
- Both requests held continuously for 4 transactions → grants alternate D,I,D,I; no ready overlap.
- rst pulsed while mem_read=1, then mem_ready arrives → outputs zero at once; stray mem_ready produces no ready pulse; the next request is served normally.
- Counter forced near all-ones with continuous contention → contention_cnt holds at all-ones.

Source files
------------

// File: rtl/mem_port_arbiter_if.sv
// Bundle of the cache-side request/response signals and the external memory
// port that mem_port_arbiter sits between.
interface mem_port_arbiter_if #(
    parameter int unsigned ADDR_W = 28,
    parameter int unsigned DATA_W = 128,
    parameter int unsigned CNT_W  = 32
);

    // I-cache miss engine
    logic              ic_read;
    logic [ADDR_W-1:0] ic_addr;
    logic              ic_ready;
    logic [DATA_W-1:0] ic_rdata;

    // D-cache miss / write-back engine
    logic              dc_read;
    logic              dc_write;
    logic [ADDR_W-1:0] dc_addr;
    logic [DATA_W-1:0] dc_wdata;
    logic              dc_ready;
    logic [DATA_W-1:0] dc_rdata;

    // External memory port
    logic              mem_read;
    logic              mem_write;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic              mem_ready;
    logic [DATA_W-1:0] mem_rdata;

    // Performance counter
    logic [CNT_W-1:0]  contention_cnt;

    // Environment side: caches and memory model
    modport master (
        output ic_read, ic_addr,
        output dc_read, dc_write, dc_addr, dc_wdata,
        output mem_ready, mem_rdata,
        input  ic_ready, ic_rdata,
        input  dc_ready, dc_rdata,
        input  mem_read, mem_write, mem_addr, mem_wdata,
        input  contention_cnt
    );

    // Arbiter side
    modport slave (
        input  ic_read, ic_addr,
        input  dc_read, dc_write, dc_addr, dc_wdata,
        input  mem_ready, mem_rdata,
        output ic_ready, ic_rdata,
        output dc_ready, dc_rdata,
        output mem_read, mem_write, mem_addr, mem_wdata,
        output contention_cnt
    );

endinterface

// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing one external memory port between the I-cache
// and D-cache engines. The granted request is latched, the memory strobe is
// held until mem_ready, and the winner gets a one-cycle ready pulse with data.
module mem_port_arbiter #(
    parameter int unsigned ADDR_W = 28,
    parameter int unsigned DATA_W = 128,
    parameter int unsigned CNT_W  = 32
) (
    input  logic               clk,
    input  logic               rst,
    mem_port_arbiter_if.slave  bus
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2
    } state_t;

    typedef enum logic {
        OWN_IC = 1'b0,
        OWN_DC = 1'b1
    } owner_t;

    // Latched transaction: who owns the port and what it asked for
    typedef struct packed {
        owner_t            owner;
        logic              write;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] wdata;
    } txn_t;

    state_t            state;
    owner_t            last_grant;
    txn_t              txn;
    logic              mem_read_q;
    logic              mem_write_q;
    logic              ic_ready_q;
    logic              dc_ready_q;
    logic [DATA_W-1:0] ic_rdata_q;
    logic [DATA_W-1:0] dc_rdata_q;
    logic [CNT_W-1:0]  cnt_q;

    logic              ic_req;
    logic              dc_req;
    logic              pick_dc;
    logic              other_waiting;
    txn_t              grant_txn;

    // Request decode, round-robin pick and the candidate transaction to latch
    always_comb begin
        ic_req        = bus.ic_read;
        dc_req        = bus.dc_read | bus.dc_write;
        pick_dc       = dc_req && (!ic_req || (last_grant == OWN_IC));
        grant_txn     = '0;
        if (pick_dc) begin
            grant_txn.owner = OWN_DC;
            grant_txn.write = bus.dc_write;  // write wins over an illegal read+write
            grant_txn.addr  = bus.dc_addr;
            grant_txn.wdata = bus.dc_wdata;
        end else begin
            grant_txn.owner = OWN_IC;
            grant_txn.write = 1'b0;
            grant_txn.addr  = bus.ic_addr;
            grant_txn.wdata = '0;
        end
        other_waiting = (txn.owner == OWN_IC) ? dc_req : ic_req;
    end

    // Port ownership FSM with registered strobes, ready pulses and return data
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            last_grant  <= OWN_IC;
            txn         <= '0;
            mem_read_q  <= 1'b0;
            mem_write_q <= 1'b0;
            ic_ready_q  <= 1'b0;
            dc_ready_q  <= 1'b0;
            ic_rdata_q  <= '0;
            dc_rdata_q  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (ic_req || dc_req) begin
                        txn         <= grant_txn;
                        mem_read_q  <= !grant_txn.write;
                        mem_write_q <= grant_txn.write;
                        state       <= BUSY;
                    end
                end
                BUSY: begin
                    if (bus.mem_ready) begin
                        mem_read_q  <= 1'b0;
                        mem_write_q <= 1'b0;
                        if (txn.owner == OWN_IC) begin
                            ic_ready_q <= 1'b1;
                            ic_rdata_q <= txn.write ? '0 : bus.mem_rdata;
                        end else begin
                            dc_ready_q <= 1'b1;
                            dc_rdata_q <= txn.write ? '0 : bus.mem_rdata;
                        end
                        state <= RESP;
                    end
                end
                RESP: begin
                    ic_ready_q <= 1'b0;
                    dc_ready_q <= 1'b0;
                    ic_rdata_q <= '0;
                    dc_rdata_q <= '0;
                    last_grant <= txn.owner;
                    state      <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // Saturating count of cycles the non-owner spends waiting for the port
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else if ((state != IDLE) && other_waiting && (cnt_q != '1)) begin
            cnt_q <= cnt_q + CNT_W'(1);
        end
    end

    assign bus.mem_read       = mem_read_q;
    assign bus.mem_write      = mem_write_q;
    assign bus.mem_addr       = txn.addr;
    assign bus.mem_wdata      = txn.wdata;
    assign bus.ic_ready       = ic_ready_q;
    assign bus.ic_rdata       = ic_rdata_q;
    assign bus.dc_ready       = dc_ready_q;
    assign bus.dc_rdata       = dc_rdata_q;
    assign bus.contention_cnt = cnt_q;

endmodule
